// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter unit.
package pc_pkg;

  // RUN: no buffered redirect; PEND: a redirect target waits for the stall to release
  typedef enum logic {
    PC_RUN  = 1'b0,
    PC_PEND = 1'b1
  } pc_state_e;

  localparam logic [31:0] PC_RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VECTOR_DEF   = 32'h8000_0080;
  localparam int unsigned PC_INCR             = 4;

endpackage

// File: rtl/pc_redirect_buffer.sv
// Holds a redirect target that arrives while fetch is stalled, until the stall releases.
module pc_redirect_buffer
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            clear_i,
  input  logic            hold_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pend_o,
  output logic            pending_o
);

  pc_state_e       state_q;
  pc_state_e       state_d;
  logic [XLEN-1:0] pend_r;

  // State register; reset drops any buffered target
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= PC_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Exception clears, a stalled redirect buffers, any unstalled edge consumes or supersedes
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = PC_RUN;
    end else if (hold_i) begin
      if (load_i) begin
        state_d = PC_PEND;
      end
    end else begin
      state_d = PC_RUN;
    end
  end

  // Target storage; latest stalled redirect overwrites an older one, validity lives in state_q
  always_ff @(posedge clk_i) begin
    if (!clear_i && hold_i && load_i) begin
      pend_r <= target_i;
    end
  end

  assign pend_o    = pend_r;
  assign pending_o = (state_q == PC_PEND);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC priority mux, PC/EPC registers and misalignment pulse.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(PC_EXC_VECTOR_DEF)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            exc_valid_i,
  input  logic [XLEN-1:0] exc_pc_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] epc_o,
  output logic            redirect_pending_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] epc_r;
  logic [XLEN-1:0] epc_d;
  logic            misalign_r;
  logic            misalign_d;
  logic            accept;
  logic [XLEN-1:0] target_al;
  logic [XLEN-1:0] pend;
  logic            pending;

  // Targets are word addresses; low two bits are dropped on the way in
  assign target_al  = {redirect_target_i[XLEN-1:2], 2'b00};
  assign pc_plus4_o = pc_r + XLEN'(PC_INCR);

  pc_redirect_buffer #(
    .XLEN (XLEN)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (exc_valid_i),
    .hold_i    (stall_i),
    .load_i    (redirect_valid_i),
    .target_i  (target_al),
    .pend_o    (pend),
    .pending_o (pending)
  );

  // Next-PC priority: exception, stall, live redirect, pending redirect, sequential
  always_comb begin
    pc_d   = pc_plus4_o;
    epc_d  = epc_r;
    accept = 1'b0;
    if (exc_valid_i) begin
      pc_d  = EXC_VECTOR;
      epc_d = exc_pc_i;
    end else if (stall_i) begin
      pc_d   = pc_r;
      accept = redirect_valid_i;
    end else if (redirect_valid_i) begin
      pc_d   = target_al;
      accept = 1'b1;
    end else if (pending) begin
      pc_d = pend;
    end
    misalign_d = accept && (redirect_target_i[1:0] != 2'b00);
  end

  // PC, EPC and misalignment pulse registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_r       <= RESET_VECTOR;
      epc_r      <= '0;
      misalign_r <= 1'b0;
    end else begin
      pc_r       <= pc_d;
      epc_r      <= epc_d;
      misalign_r <= misalign_d;
    end
  end

  assign pc_o               = pc_r;
  assign epc_o              = epc_r;
  assign redirect_pending_o = pending;
  assign misalign_o         = misalign_r;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: inputs change and outputs are sampled on the falling edge.
module tb_pc_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic        exc_valid_i;
  logic [31:0] exc_pc_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] epc_o;
  logic        redirect_pending_o;
  logic        misalign_o;

  int vectors    = 0;
  int miscompares = 0;

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .EXC_VECTOR   (32'h8000_0080)
  ) dut (
    .clk_i              (clk_i),
    .rst_n_i            (rst_n_i),
    .stall_i            (stall_i),
    .redirect_valid_i   (redirect_valid_i),
    .redirect_target_i  (redirect_target_i),
    .exc_valid_i        (exc_valid_i),
    .exc_pc_i           (exc_pc_i),
    .pc_o               (pc_o),
    .pc_plus4_o         (pc_plus4_o),
    .epc_o              (epc_o),
    .redirect_pending_o (redirect_pending_o),
    .misalign_o         (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic idle();
    stall_i           = 1'b0;
    redirect_valid_i  = 1'b0;
    redirect_target_i = 32'h0;
    exc_valid_i       = 1'b0;
    exc_pc_i          = 32'h0;
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  initial begin
    rst_n_i = 1'b0;
    idle();
    tick();
    check("rst_pc", pc_o, 32'h0);
    check("rst_epc", epc_o, 32'h0);
    check("rst_pend", {31'b0, redirect_pending_o}, 32'h0);
    check("rst_mis", {31'b0, misalign_o}, 32'h0);

    // sequential fetch
    rst_n_i = 1'b1;
    tick();
    check("seq_pc4", pc_o, 32'h4);
    check("seq_plus4", pc_plus4_o, 32'h8);
    tick();
    check("seq_pc8", pc_o, 32'h8);
    tick();
    check("seq_pc12", pc_o, 32'hC);

    // redirect during a 3-cycle stall
    stall_i = 1'b1; redirect_valid_i = 1'b1; redirect_target_i = 32'h100;
    tick();
    check("stl_hold1", pc_o, 32'hC);
    check("stl_pend1", {31'b0, redirect_pending_o}, 32'h1);
    redirect_valid_i = 1'b0; redirect_target_i = 32'h0;
    tick();
    check("stl_hold2", pc_o, 32'hC);
    tick();
    check("stl_hold3", pc_o, 32'hC);
    check("stl_pend3", {31'b0, redirect_pending_o}, 32'h1);
    stall_i = 1'b0;
    tick();
    check("stl_rel_pc", pc_o, 32'h100);
    check("stl_rel_pend", {31'b0, redirect_pending_o}, 32'h0);
    tick();
    check("stl_after", pc_o, 32'h104);

    // two redirects in one stall: latest wins
    stall_i = 1'b1; redirect_valid_i = 1'b1; redirect_target_i = 32'h200;
    tick();
    redirect_target_i = 32'h300;
    tick();
    check("two_hold", pc_o, 32'h104);
    idle();
    tick();
    check("two_pc", pc_o, 32'h300);

    // exception beats stall, redirect and a pending target
    stall_i = 1'b1; redirect_valid_i = 1'b1; redirect_target_i = 32'h400;
    tick();
    check("exc_prepend", {31'b0, redirect_pending_o}, 32'h1);
    exc_valid_i = 1'b1; exc_pc_i = 32'h40; redirect_target_i = 32'h500;
    tick();
    check("exc_pc", pc_o, 32'h8000_0080);
    check("exc_epc", epc_o, 32'h40);
    check("exc_pend", {31'b0, redirect_pending_o}, 32'h0);
    idle();
    tick();
    check("exc_next", pc_o, 32'h8000_0084);

    // misaligned target: forced aligned, one-cycle pulse; epc untouched by redirect
    redirect_valid_i = 1'b1; redirect_target_i = 32'h103;
    tick();
    check("mis_pc", pc_o, 32'h100);
    check("mis_hi", {31'b0, misalign_o}, 32'h1);
    check("mis_epc", epc_o, 32'h40);
    idle();
    tick();
    check("mis_lo", {31'b0, misalign_o}, 32'h0);
    check("mis_next", pc_o, 32'h104);

    // misaligned target buffered during stall
    stall_i = 1'b1; redirect_valid_i = 1'b1; redirect_target_i = 32'h222;
    tick();
    check("mis_stl_hi", {31'b0, misalign_o}, 32'h1);
    idle();
    tick();
    check("mis_stl_pc", pc_o, 32'h220);
    check("mis_stl_lo", {31'b0, misalign_o}, 32'h0);

    // live redirect supersedes pending one
    stall_i = 1'b1; redirect_valid_i = 1'b1; redirect_target_i = 32'h400;
    tick();
    stall_i = 1'b0; redirect_target_i = 32'h600;
    tick();
    check("sup_pc", pc_o, 32'h600);
    check("sup_pend", {31'b0, redirect_pending_o}, 32'h0);
    idle();
    tick();
    check("sup_next", pc_o, 32'h604);

    // wrap at top of address space
    redirect_valid_i = 1'b1; redirect_target_i = 32'hFFFF_FFFC;
    tick();
    check("wrap_pc", pc_o, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4_o, 32'h0);
    idle();
    tick();
    check("wrap_next", pc_o, 32'h0);

    // asynchronous reset while pending discards the buffered target
    stall_i = 1'b1; redirect_valid_i = 1'b1; redirect_target_i = 32'h700;
    tick();
    check("ar_pend", {31'b0, redirect_pending_o}, 32'h1);
    redirect_valid_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    check("ar_pc", pc_o, 32'h0);
    check("ar_epc", epc_o, 32'h0);
    check("ar_pendc", {31'b0, redirect_pending_o}, 32'h0);
    idle();
    tick();
    rst_n_i = 1'b1;
    tick();
    check("ar_after", pc_o, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
